// File: rtl/guitar_io_bridge_pkg.sv
// Shared definitions for the Guitar Hero I/O bridge: register offsets,
// STATUS/EVENT/CTRL bit positions, the load-source selector and the event packer.
package guitar_io_bridge_pkg;

  localparam logic [3:0] OFF_STATUS = 4'h0;
  localparam logic [3:0] OFF_EVENT  = 4'h1;
  localparam logic [3:0] OFF_TICK   = 4'h2;
  localparam logic [3:0] OFF_SCORE  = 4'h3;
  localparam logic [3:0] OFF_CTRL   = 4'h4;

  localparam int ST_EMPTY = 8;
  localparam int ST_FULL  = 9;
  localparam int ST_OVF   = 10;

  localparam int CTRL_CLR_OVF  = 0;
  localparam int CTRL_CLR_TICK = 1;

  localparam int EV_VALID    = 31;
  localparam int EV_TICK_LSB = 8;
  localparam int EV_MASK_LSB = 0;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_RAM,
    SRC_IO
  } rd_src_e;

  // Event word: valid flag, 7 reserved zeros, tick stamp, lane hit mask.
  function automatic logic [31:0] make_event(input logic [15:0] tick, input logic [7:0] mask);
    return {1'b1, 7'b0, tick, mask};
  endfunction

endpackage

// File: rtl/guitar_io_bridge_sync_fifo.sv
// Synchronous FIFO with combinational head data; pops on empty and pushes on
// full (without a simultaneous pop) are ignored.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot the concurrent push needs, so full+push+pop proceeds.
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // NOTE: storage is not reset; only the pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/guitar_io_bridge.sv
// Memory-mapped bridge between the processor dmem port, RAM and the guitar
// peripherals: synchronisers, strum debounce, tick counter, score and hit-event FIFO.
module guitar_io_bridge
  import guitar_io_bridge_pkg::*;
#(
  parameter int         LANES      = 4,
  parameter int         ADDR_W     = 12,
  parameter int         FIFO_DEPTH = 8,
  parameter int         DEB_CYCLES = 16,
  parameter logic [3:0] IO_PAGE    = 4'hF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       address_dmem,
  input  logic [31:0]       data,
  input  logic              wren,
  output logic [31:0]       q_dmem,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wEn,
  output logic [31:0]       ram_dataIn,
  input  logic [31:0]       ram_dataOut,
  input  logic [LANES-1:0]  buttons,
  input  logic [LANES-1:0]  intersections,
  input  logic              strum,
  input  logic              gameclk,
  output logic [31:0]       score,
  output logic              irq_event
);

  localparam int DEB_W = $clog2(DEB_CYCLES) + 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [LANES-1:0] btn_s1, btn_sync;
  logic [LANES-1:0] int_s1, int_sync;
  logic             strum_s1, strum_sync;
  logic             gclk_s1, gclk_sync, gclk_prev;

  logic             deb_level;
  logic [DEB_W-1:0] deb_cnt;
  logic             deb_accept;

  logic [31:0] tick_q;
  logic [31:0] score_q;
  logic        ovf_q;
  logic        irq_q;
  rd_src_e     rd_src_q;
  logic [31:0] io_rdata_q;

  logic        io_sel;
  logic [3:0]  offset;
  logic        io_wr;
  logic        ctrl_wr;
  logic        ev_pop;
  logic        ev_push;
  logic [31:0] ev_word;
  logic [31:0] io_rdata;

  logic [31:0]                   fifo_head;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          unused_ok;

  assign unused_ok = ^{address_dmem[31:ADDR_W], fifo_count};

  assign io_sel     = (address_dmem[ADDR_W-1 -: 4] == IO_PAGE);
  assign offset     = address_dmem[3:0];
  assign io_wr      = io_sel & wren;
  assign ctrl_wr    = io_wr & (offset == OFF_CTRL);
  assign ev_pop     = io_sel & ~wren & (offset == OFF_EVENT);
  assign ram_addr   = address_dmem[ADDR_W-1:0];
  assign ram_wEn    = wren & ~io_sel;
  assign ram_dataIn = data;
  assign score      = score_q;
  assign irq_event  = irq_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_s1     <= '0;
      btn_sync   <= '0;
      int_s1     <= '0;
      int_sync   <= '0;
      strum_s1   <= 1'b0;
      strum_sync <= 1'b0;
      gclk_s1    <= 1'b0;
      gclk_sync  <= 1'b0;
      gclk_prev  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep each flop stage one cycle behind the previous.
      btn_s1     <= buttons;
      btn_sync   <= btn_s1;
      int_s1     <= intersections;
      int_sync   <= int_s1;
      strum_s1   <= strum;
      strum_sync <= strum_s1;
      gclk_s1    <= gameclk;
      gclk_sync  <= gclk_s1;
      gclk_prev  <= gclk_sync;
    end
  end

  // The cycle in which the counter shows DEB_CYCLES-1 is the DEB_CYCLES-th stable one.
  assign deb_accept = (strum_sync != deb_level) && (deb_cnt == DEB_LAST);
  assign ev_push    = deb_accept & strum_sync;
  assign ev_word    = make_event(tick_q[15:0], 8'(btn_sync & int_sync));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      deb_level <= 1'b0;
      deb_cnt   <= '0;
    end else if (strum_sync == deb_level) begin
      deb_cnt <= '0;
    end else if (deb_accept) begin
      deb_level <= strum_sync;
      deb_cnt   <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (ev_push),
    .pop   (ev_pop),
    .wdata (ev_word),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_q  <= '0;
      score_q <= '0;
      ovf_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (ctrl_wr && data[CTRL_CLR_TICK])  tick_q <= '0;
      else if (gclk_sync && !gclk_prev)    tick_q <= tick_q + 1'b1;
      if (io_wr && offset == OFF_SCORE)    score_q <= data;
      if (ev_push && fifo_full && !ev_pop) ovf_q <= 1'b1;
      else if (ctrl_wr && data[CTRL_CLR_OVF]) ovf_q <= 1'b0;
      irq_q <= ~fifo_empty;
    end
  end

  // NOTE: every variable gets a default first so no path leaves a latch behind.
  always_comb begin
    io_rdata = '0;
    case (offset)
      OFF_STATUS: begin
        io_rdata[LANES-1:0] = btn_sync;
        io_rdata[ST_EMPTY]  = fifo_empty;
        io_rdata[ST_FULL]   = fifo_full;
        io_rdata[ST_OVF]    = ovf_q;
      end
      OFF_EVENT: io_rdata = fifo_head;
      OFF_TICK:  io_rdata = tick_q;
      OFF_SCORE: io_rdata = score_q;
      default:   io_rdata = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_src_q   <= SRC_NONE;
      io_rdata_q <= '0;
    end else begin
      rd_src_q   <= io_sel ? SRC_IO : SRC_RAM;
      io_rdata_q <= io_rdata;
    end
  end

  always_comb begin
    q_dmem = '0;
    case (rd_src_q)
      SRC_IO:  q_dmem = io_rdata_q;
      SRC_RAM: q_dmem = ram_dataOut;
      default: q_dmem = '0;
    endcase
  end

endmodule

// File: tb/tb_guitar_io_bridge.sv
// Directed bench for guitar_io_bridge with a RAM model and an event scoreboard
// that is filled as strums are driven and drained through EVENT loads.
module tb_guitar_io_bridge;

  localparam int DEB   = 16;
  localparam int DEPTH = 8;
  localparam logic [31:0] IDLE      = 32'h0000_0000;
  localparam logic [31:0] A_STATUS  = 32'h0000_0F00;
  localparam logic [31:0] A_EVENT   = 32'h0000_0F01;
  localparam logic [31:0] A_TICK    = 32'h0000_0F02;
  localparam logic [31:0] A_SCORE   = 32'h0000_0F03;
  localparam logic [31:0] A_CTRL    = 32'h0000_0F04;
  localparam logic [31:0] A_UNMAP   = 32'h0000_0F07;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address_dmem = IDLE;
  logic [31:0] data = '0;
  logic        wren = 1'b0;
  logic [31:0] q_dmem;
  logic [11:0] ram_addr;
  logic        ram_wEn;
  logic [31:0] ram_dataIn;
  logic [31:0] ram_dataOut;
  logic [3:0]  buttons = '0;
  logic [3:0]  intersections = '0;
  logic        strum = 1'b0;
  logic        gameclk = 1'b0;
  logic [31:0] score;
  logic        irq_event;

  logic [31:0] ram_mem [4096];
  logic [31:0] exp_q [$];
  logic [31:0] exp_tick;
  logic [31:0] rd;
  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  guitar_io_bridge dut (
    .clock         (clock),
    .reset         (reset),
    .address_dmem  (address_dmem),
    .data          (data),
    .wren          (wren),
    .q_dmem        (q_dmem),
    .ram_addr      (ram_addr),
    .ram_wEn       (ram_wEn),
    .ram_dataIn    (ram_dataIn),
    .ram_dataOut   (ram_dataOut),
    .buttons       (buttons),
    .intersections (intersections),
    .strum         (strum),
    .gameclk       (gameclk),
    .score         (score),
    .irq_event     (irq_event)
  );

  always @(posedge clock) begin
    if (ram_wEn) ram_mem[ram_addr] <= ram_dataIn;
    ram_dataOut <= ram_mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] d);
    address_dmem = addr;
    data = d;
    wren = 1'b1;
    cyc(1);
    wren = 1'b0;
    address_dmem = IDLE;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] r);
    address_dmem = addr;
    wren = 1'b0;
    cyc(1);
    r = q_dmem;
    address_dmem = IDLE;
  endtask

  task automatic pulse_gclk();
    gameclk = 1'b1;
    cyc(3);
    gameclk = 1'b0;
    cyc(3);
    exp_tick = exp_tick + 1;
  endtask

  task automatic strum_hit();
    strum = 1'b1;
    cyc(DEB + 3);
    strum = 1'b0;
    cyc(DEB + 3);
  endtask

  function automatic logic [31:0] ev(input logic [31:0] t, input logic [3:0] b, input logic [3:0] i);
    return 32'h8000_0000 | {8'h00, t[15:0], 8'h00} | {24'h0, 4'h0, b & i};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog expired before the directed sequence completed");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 4096; a++) ram_mem[a] = '0;
    exp_tick = '0;
    cyc(3);
    check("reset_q_dmem", q_dmem, 32'h0);
    check("reset_score", score, 32'h0);
    check("reset_irq", {31'b0, irq_event}, 32'h0);
    reset = 1'b0;
    cyc(2);

    // RAM passthrough
    address_dmem = 32'h0000_0010;
    data = 32'h0000_1234;
    wren = 1'b1;
    #1;
    check("ram_wen_store", {31'b0, ram_wEn}, 32'h1);
    cyc(1);
    wren = 1'b0;
    address_dmem = IDLE;
    bus_read(32'h0000_0010, rd);
    check("ram_load", rd, 32'h0000_1234);
    address_dmem = A_TICK;
    wren = 1'b1;
    #1;
    check("ram_wen_io_store", {31'b0, ram_wEn}, 32'h0);
    cyc(1);
    wren = 1'b0;
    address_dmem = IDLE;
    check("ram_no_irq", {31'b0, irq_event}, 32'h0);
    bus_read(A_TICK, rd);
    check("tick_ro_ignored", rd, 32'h0);

    // Debounced hit at TICK=5
    buttons = 4'b0110;
    intersections = 4'b0100;
    repeat (5) pulse_gclk();
    bus_read(A_TICK, rd);
    check("tick_five", rd, exp_tick);
    strum_hit();
    exp_q.push_back(ev(exp_tick, buttons, intersections));
    check("hit_irq", {31'b0, irq_event}, 32'h1);
    bus_read(A_EVENT, rd);
    check("hit_event", rd, exp_q.pop_front());
    check("hit_event_literal", rd, 32'h8000_0504);
    cyc(2);
    bus_read(A_STATUS, rd);
    check("hit_status_empty", rd, 32'h0000_0106);
    check("hit_irq_clear", {31'b0, irq_event}, 32'h0);

    // Bounce: strum never stable long enough
    for (int k = 0; k < 40; k += 3) begin
      strum = ~strum;
      cyc(3);
    end
    strum = 1'b0;
    cyc(DEB + 6);
    check("bounce_irq", {31'b0, irq_event}, 32'h0);
    bus_read(A_STATUS, rd);
    check("bounce_empty", rd[8] ? 32'h1 : 32'h0, 32'h1);

    // Overflow: DEPTH+2 strums, no pops
    intersections = 4'hF;
    for (int i = 0; i < DEPTH + 2; i++) begin
      buttons = (i == 3) ? 4'h0 : 4'(i + 1);
      pulse_gclk();
      strum_hit();
      if (exp_q.size() < DEPTH) exp_q.push_back(ev(exp_tick, buttons, intersections));
    end
    bus_read(A_STATUS, rd);
    check("ovf_status", rd, 32'h0000_0600 | {28'h0, buttons});
    bus_write(A_CTRL, 32'h1);
    bus_read(A_STATUS, rd);
    check("ovf_cleared", rd, 32'h0000_0200 | {28'h0, buttons});

    // Full FIFO: strum edge accepted in the same cycle as an EVENT load
    buttons = 4'b1001;
    intersections = 4'b1000;
    strum = 1'b1;
    cyc(DEB + 1);
    bus_read(A_EVENT, rd);
    check("fullpop_head", rd, exp_q.pop_front());
    exp_q.push_back(ev(exp_tick, buttons, intersections));
    strum = 1'b0;
    cyc(DEB + 3);
    bus_read(A_STATUS, rd);
    check("fullpop_status", rd, 32'h0000_0209);
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(A_EVENT, rd);
      check($sformatf("drain_%0d", i), rd, exp_q.pop_front());
    end
    bus_read(A_EVENT, rd);
    check("empty_event_zero", rd, 32'h0);
    bus_read(A_STATUS, rd);
    check("drained_status", rd, 32'h0000_0109);
    bus_read(A_CTRL, rd);
    check("ctrl_reads_zero", rd, 32'h0);
    bus_read(A_UNMAP, rd);
    check("unmapped_zero", rd, 32'h0);
    bus_write(A_CTRL, 32'h2);
    exp_tick = '0;
    bus_read(A_TICK, rd);
    check("tick_cleared", rd, exp_tick);

    // Score and reset mid-burst
    bus_write(A_SCORE, 32'd42);
    check("score_out", score, 32'd42);
    bus_read(A_SCORE, rd);
    check("score_read", rd, 32'd42);
    pulse_gclk();
    strum_hit();
    check("burst_irq", {31'b0, irq_event}, 32'h1);
    strum = 1'b1;
    gameclk = 1'b1;
    cyc(5);
    #2;
    reset = 1'b1;
    #1;
    check("rst_q_dmem", q_dmem, 32'h0);
    check("rst_score", score, 32'h0);
    check("rst_irq", {31'b0, irq_event}, 32'h0);
    cyc(2);
    check("rst_hold_q_dmem", q_dmem, 32'h0);
    strum = 1'b0;
    gameclk = 1'b0;
    reset = 1'b0;
    exp_q.delete();
    exp_tick = '0;
    cyc(DEB + 5);
    bus_read(A_TICK, rd);
    check("post_rst_tick", rd, exp_tick);
    bus_read(A_STATUS, rd);
    check("post_rst_status", rd, 32'h0000_0109);
    bus_read(A_SCORE, rd);
    check("post_rst_score", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
